imm_gen_pipe: RTL

- Parametrised, pipelined immediate generator for the decode stage; next generation of the combinational immediate splicer.
- Adds XLEN generalisation (32/64), optional RVC immediate decoding, an immediate-type tag, and a registered valid/ready output stage with a 2-entry skid buffer so it can sit between fetch and decode without a combinational ready path.

---
 rtl/imm_gen_pipe.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes RV32/64 (and optional RVC) immediates
// into a 2-entry skid FIFO so upstream ready never depends on downstream ready.
module imm_gen_pipe #(
    parameter int XLEN     = 32,
    parameter int RVC_EN   = 1,
    parameter int OPW64_EN = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            inValid,
    output logic            inReady,
    input  logic [31:0]     instIn,
    output logic            outValid,
    input  logic            outReady,
    output logic [XLEN-1:0] immOut,
    output logic [2:0]      immType,
    output logic            isCompressed
);

    localparam logic [2:0] TY_NONE = 3'd0;
    localparam logic [2:0] TY_I    = 3'd1;
    localparam logic [2:0] TY_S    = 3'd2;
    localparam logic [2:0] TY_B    = 3'd3;
    localparam logic [2:0] TY_U    = 3'd4;
    localparam logic [2:0] TY_J    = 3'd5;
    localparam logic [2:0] TY_CI   = 3'd6;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      typ;
        logic            comp;
    } entry_t;

    entry_t      dec;
    entry_t      mem [2];
    entry_t      head;
    logic [1:0]  count;
    logic        rd_ptr, wr_ptr;
    logic        push, pop;
    logic [6:0]  op;
    logic [15:0] c;

    assign op = instIn[6:0];
    assign c  = instIn[15:0];

    always_comb begin
        dec = '0;
        if (RVC_EN != 0 && instIn[1:0] != 2'b11) begin
            dec.comp = 1'b1;
            case ({c[1:0], c[15:13]})
                5'b01000, 5'b01010: begin
                    dec.imm = XLEN'($signed({c[12], c[6:2]}));
                    dec.typ = TY_CI;
                end
                5'b01011: begin
                    // rd==2 is C.ADDI16SP, which has no immediate of this shape
                    if (c[11:7] != 5'd2) begin
                        dec.imm = XLEN'($signed({c[12], c[6:2], 12'b0}));
                        dec.typ = TY_CI;
                    end
                end
                5'b01101: begin
                    dec.imm = XLEN'($signed({c[12], c[8], c[10:9], c[6], c[7],
                                             c[2], c[11], c[5:3], 1'b0}));
                    dec.typ = TY_CI;
                end
                5'b01110, 5'b01111: begin
                    dec.imm = XLEN'($signed({c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0}));
                    dec.typ = TY_CI;
                end
                5'b00010, 5'b00110: begin
                    dec.imm = XLEN'({c[5], c[12:10], c[6], 2'b00});
                    dec.typ = TY_CI;
                end
                default: ;
            endcase
        end else begin
            case (op)
                7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                    dec.imm = XLEN'($signed(instIn[31:20]));
                    dec.typ = TY_I;
                end
                7'b0011011: begin
                    if (OPW64_EN != 0 && XLEN == 64) begin
                        dec.imm = XLEN'($signed(instIn[31:20]));
                        dec.typ = TY_I;
                    end
                end
                7'b0100011: begin
                    dec.imm = XLEN'($signed({instIn[31:25], instIn[11:7]}));
                    dec.typ = TY_S;
                end
                7'b1100011: begin
                    dec.imm = XLEN'($signed({instIn[31], instIn[7], instIn[30:25],
                                             instIn[11:8], 1'b0}));
                    dec.typ = TY_B;
                end
                7'b0110111, 7'b0010111: begin
                    dec.imm = XLEN'($signed({instIn[31:12], 12'b0}));
                    dec.typ = TY_U;
                end
                7'b1101111: begin
                    dec.imm = XLEN'($signed({instIn[31], instIn[19:12], instIn[20],
                                             instIn[30:21], 1'b0}));
                    dec.typ = TY_J;
                end
                default: ;
            endcase
        end
    end

    // Ready comes from the registered count only, so a pop frees a slot next cycle.
    assign inReady  = (count < 2'd2);
    assign outValid = (count != 2'd0);
    assign push     = inValid & inReady;
    assign pop      = outValid & outReady;
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= dec;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign immOut       = outValid ? head.imm  : '0;
    assign immType      = outValid ? head.typ  : TY_NONE;
    assign isCompressed = outValid ? head.comp : 1'b0;

endmodule
